// File: rtl/popcount255_pipe.sv
// Population count of a 255-bit vector using a 2-stage registered adder tree.
// Stage 1 registers 15 partial counts of 17 bits each; stage 2 registers their total.
module popcount255_pipe #(
  parameter int IN_WIDTH   = 255,
  parameter int OUT_WIDTH  = 8,
  parameter int GROUP_SIZE = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  din,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] dout
);

  localparam int NUM_GROUPS = IN_WIDTH / GROUP_SIZE;
  localparam int PSUM_W     = $clog2(GROUP_SIZE + 1);

  // Valid semantics: in_valid qualifies din in the same cycle; out_valid
  // qualifies dout exactly two rising edges later. There is no backpressure.
  // Data registers load every cycle; only the valid bit gives them meaning.

  logic [NUM_GROUPS-1:0][PSUM_W-1:0] psum_d;
  logic [NUM_GROUPS-1:0][PSUM_W-1:0] psum_q;
  logic                              v1;
  logic [OUT_WIDTH-1:0]              sum_d;

  always_comb begin
    psum_d = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int b = 0; b < GROUP_SIZE; b++) begin
        psum_d[g] = psum_d[g] + PSUM_W'(din[g*GROUP_SIZE + b]);
      end
    end
  end

  // The total is at most 255, so an OUT_WIDTH accumulator never wraps.
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      sum_d = sum_d + OUT_WIDTH'(psum_q[g]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_q    <= '0;
      v1        <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      psum_q    <= psum_d;
      v1        <= in_valid;
      dout      <= sum_d;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_popcount255_pipe.sv
// Self-checking bench for popcount255_pipe: directed literals, reset and
// randomized streams compared against a bit-counting reference model.
module tb_popcount255_pipe;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [254:0] din;
  logic         out_valid;
  logic [7:0]   dout;

  int checks = 0;
  int errors = 0;

  popcount255_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .din       (din),
    .out_valid (out_valid),
    .dout      (dout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_count(input logic [254:0] v);
    int n = 0;
    for (int i = 0; i < 255; i++) n += int'(v[i]);
    return n;
  endfunction

  logic [7:0] exp_q[$];
  logic       m_v1 = 1'b0;
  logic       m_v2 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_v1 = 1'b0;
      m_v2 = 1'b0;
    end else begin
      m_v2 = m_v1;
      m_v1 = in_valid;
      if (in_valid) exp_q.push_back(8'(ref_count(din)));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_dout", int'(dout), 0);
    end else begin
      check("out_valid_delay", int'(out_valid), int'(m_v2));
      if (m_v2) begin
        if (exp_q.size() == 0) begin
          check("model_queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout_model", int'(dout), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [254:0] d);
    @(negedge clk);
    in_valid = v;
    din      = d;
  endtask

  function automatic logic [254:0] rand_vec();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[254:0];
  endfunction

  logic [254:0] dir_din[13];
  int           dir_exp[13];

  initial begin
    logic [254:0] v;
    in_valid = 1'b0;
    din      = '0;
    reset    = 1'b1;
    #1;
    check("por_out_valid", int'(out_valid), 0);
    check("por_dout", int'(dout), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Hand-computed literals: small values, extremes, group boundary.
    dir_din[0]  = 255'h0;            dir_exp[0]  = 0;
    dir_din[1]  = 255'h1;            dir_exp[1]  = 1;
    dir_din[2]  = 255'h3;            dir_exp[2]  = 2;
    dir_din[3]  = 255'h7;            dir_exp[3]  = 3;
    dir_din[4]  = 255'hAAAA;         dir_exp[4]  = 8;
    dir_din[5]  = 255'hF00000;       dir_exp[5]  = 4;
    dir_din[6]  = 255'h0;            dir_exp[6]  = 0;
    dir_din[7]  = '1;                dir_exp[7]  = 255;
    dir_din[8]  = '0;                dir_exp[8]  = 0;
    dir_din[9]  = {1'b1, 254'b0};    dir_exp[9]  = 1;
    dir_din[10] = 255'h1;            dir_exp[10] = 1;
    dir_din[11] = 255'h30000;        dir_exp[11] = 2;
    dir_din[12] = 255'({128{2'b01}}); dir_exp[12] = 128;

    // Back-to-back stream: result k visible at the negedge two cycles later.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("lit_valid", int'(out_valid), 1);
        check("lit_dout", int'(dout), dir_exp[k-2]);
      end
      in_valid = (k < 13);
      din      = (k < 13) ? dir_din[k] : '0;
    end

    // Asynchronous reset with all-ones samples in flight.
    for (int k = 0; k < 3; k++) drive(1'b1, '1);
    @(posedge clk);
    #2;
    check("pre_reset_dout", int'(dout), 255);
    reset = 1'b1;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_dout", int'(dout), 0);
    @(negedge clk);
    in_valid = 1'b0;
    din      = '1;
    reset    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_quiet", int'(out_valid), 0);
    end
    in_valid = 1'b1;
    din      = 255'h30000;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_after_reset_lat1", int'(out_valid), 0);
    @(negedge clk);
    check("first_after_reset_lat2", int'(out_valid), 1);
    check("first_after_reset_dout", int'(dout), 2);

    // Randomized stream with toggling valid and biased density.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0:       v = '1;
        1:       v = rand_vec() & rand_vec() & rand_vec();
        2:       v = rand_vec() | rand_vec();
        default: v = rand_vec();
      endcase
      drive($urandom_range(0, 3) != 0, v);
    end
    drive(1'b0, '0);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
